// File: rtl/id_stage_pipe.sv
// Elastic MIPS decode stage: decode, RF read and operand bypass, with a load-use interlock and a j/jr redirect.
// Optional feature macro: ID_FWD_EN (EX/MEM bypass); without it, any pending EX/MEM write to a used source stalls.
module id_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc_in,
  output logic [REG_AW-1:0] rf_raddr0,
  output logic [REG_AW-1:0] rf_raddr1,
  input  logic [DATA_W-1:0] rf_rdata0,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic              ex_wr_en,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_wr_addr,
  input  logic [DATA_W-1:0] ex_wr_data,
  input  logic              mem_wr_en,
  input  logic [REG_AW-1:0] mem_wr_addr,
  input  logic [DATA_W-1:0] mem_wr_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op1,
  output logic [DATA_W-1:0] out_op2,
  output logic [DATA_W-1:0] out_imm,
  output logic [4:0]        out_shamt,
  output logic [REG_AW-1:0] out_dest,
  output logic [3:0]        out_alu_func,
  output logic [1:0]        out_mem_op,
  output logic              out_opb_imm,
  output logic [1:0]        out_br_type,
  output logic [DATA_W-1:0] out_br_target,
  output logic              out_illegal,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc
);

  localparam logic [3:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3,
                         ALU_OR  = 4'd4, ALU_XOR = 4'd5, ALU_NOR = 4'd6, ALU_SRA = 4'd7,
                         ALU_SLT = 4'd8;

  logic [5:0]        opcode, funct;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [3:0]        d_alu;
  logic [1:0]        d_mem, d_br;
  logic              d_opb, d_ill, d_zext, use_rs, use_rt, is_j, is_jr;
  logic [REG_AW-1:0] d_dest;
  logic [DATA_W-1:0] simm, d_imm, j_target;

  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];
  assign rs        = REG_AW'(instr[25:21]);
  assign rt        = REG_AW'(instr[20:16]);
  assign rd        = REG_AW'(instr[15:11]);
  assign rf_raddr0 = rs;
  assign rf_raddr1 = rt;

  always_comb begin
    d_alu  = ALU_NOP;
    d_mem  = 2'd0;
    d_br   = 2'd0;
    d_opb  = 1'b0;
    d_ill  = 1'b0;
    d_zext = 1'b0;
    d_dest = '0;
    use_rs = 1'b0;
    use_rt = 1'b0;
    is_j   = 1'b0;
    is_jr  = 1'b0;
    case (opcode)
      6'h00: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
        d_dest = rd;
        case (funct)
          6'h20: d_alu = ALU_ADD;
          6'h22: d_alu = ALU_SUB;
          6'h24: d_alu = ALU_AND;
          6'h25: d_alu = ALU_OR;
          6'h26: d_alu = ALU_XOR;
          6'h27: d_alu = ALU_NOR;
          6'h2a: d_alu = ALU_SLT;
          6'h03: begin d_alu = ALU_SRA; use_rs = 1'b0; end
          6'h08: begin is_jr = 1'b1; use_rt = 1'b0; d_dest = '0; end
          default: begin d_ill = 1'b1; use_rs = 1'b0; use_rt = 1'b0; d_dest = '0; end
        endcase
      end
      6'h08: begin d_alu = ALU_ADD; d_opb = 1'b1; use_rs = 1'b1; d_dest = rt; end
      6'h0a: begin d_alu = ALU_SLT; d_opb = 1'b1; use_rs = 1'b1; d_dest = rt; end
      6'h0c: begin d_alu = ALU_AND; d_opb = 1'b1; use_rs = 1'b1; d_dest = rt; d_zext = 1'b1; end
      6'h0d: begin d_alu = ALU_OR;  d_opb = 1'b1; use_rs = 1'b1; d_dest = rt; d_zext = 1'b1; end
      6'h0e: begin d_alu = ALU_XOR; d_opb = 1'b1; use_rs = 1'b1; d_dest = rt; d_zext = 1'b1; end
      6'h23: begin d_alu = ALU_ADD; d_opb = 1'b1; use_rs = 1'b1; d_dest = rt; d_mem = 2'd1; end
      6'h2b: begin d_alu = ALU_ADD; d_opb = 1'b1; use_rs = 1'b1; use_rt = 1'b1; d_mem = 2'd2; end
      // Branches drive a subtract so EX can compare rs against rt (or against zero for bgtz).
      6'h04: begin d_alu = ALU_SUB; d_br = 2'd1; use_rs = 1'b1; use_rt = 1'b1; end
      6'h05: begin d_alu = ALU_SUB; d_br = 2'd2; use_rs = 1'b1; use_rt = 1'b1; end
      6'h07: begin d_alu = ALU_SUB; d_br = 2'd3; use_rs = 1'b1; end
      6'h02: is_j = 1'b1;
      default: d_ill = 1'b1;
    endcase
  end

  assign simm     = {{(DATA_W-16){instr[15]}}, instr[15:0]};
  assign d_imm    = d_zext ? {{(DATA_W-16){1'b0}}, instr[15:0]} : simm;
  assign j_target = {pc_in[DATA_W-1:28], instr[25:0], 2'b00};

  logic [1:0][REG_AW-1:0] src_addr;
  logic [1:0][DATA_W-1:0] src_rdata;
  logic [1:0][DATA_W-1:0] src_val;
  logic [1:0]             src_use;
  logic [1:0]             src_haz;

  assign src_addr  = {rt, rs};
  assign src_rdata = {rf_rdata1, rf_rdata0};
  assign src_use   = {use_rt, use_rs};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
`ifdef ID_FWD_EN
      // Youngest producer wins; a load still in EX has no data yet and is caught by the interlock.
      assign src_val[gi] = (src_addr[gi] == '0) ? '0 :
                           (ex_wr_en  && ex_wr_addr  == src_addr[gi]) ? ex_wr_data  :
                           (mem_wr_en && mem_wr_addr == src_addr[gi]) ? mem_wr_data :
                           src_rdata[gi];
      assign src_haz[gi] = src_use[gi] && (src_addr[gi] != '0) &&
                           ex_wr_en && ex_is_load && (ex_wr_addr == src_addr[gi]);
`else
      assign src_val[gi] = (src_addr[gi] == '0) ? '0 : src_rdata[gi];
      assign src_haz[gi] = src_use[gi] && (src_addr[gi] != '0) &&
                           ((ex_wr_en  && ex_wr_addr  == src_addr[gi]) ||
                            (mem_wr_en && mem_wr_addr == src_addr[gi]));
`endif
    end
  endgenerate

  logic hazard, slot_free, accept;

  assign hazard         = |src_haz;
  assign slot_free      = !out_valid || out_ready;
  assign in_ready       = flush || (slot_free && !hazard);
  assign accept         = in_valid && slot_free && !hazard && !flush;
  assign redirect_valid = accept && (is_j || is_jr);
  assign redirect_pc    = is_jr ? src_val[0] : j_target;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      out_op1       <= '0;
      out_op2       <= '0;
      out_imm       <= '0;
      out_shamt     <= '0;
      out_dest      <= '0;
      out_alu_func  <= '0;
      out_mem_op    <= '0;
      out_opb_imm   <= 1'b0;
      out_br_type   <= '0;
      out_br_target <= '0;
      out_illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_op1       <= src_val[0];
      out_op2       <= src_val[1];
      out_imm       <= d_imm;
      out_shamt     <= instr[10:6];
      out_dest      <= d_dest;
      out_alu_func  <= d_alu;
      out_mem_op    <= d_mem;
      out_opb_imm   <= d_opb;
      out_br_type   <= d_br;
      out_br_target <= pc_in + (simm << 2);
      out_illegal   <= d_ill;
    end else if (slot_free) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: a spec-level decode model queues expected slots, a monitor checks them.
module tb_id_stage_pipe;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, in_ready, ex_wr_en, ex_is_load, mem_wr_en, flush;
  logic          out_valid, out_ready, out_opb_imm, out_illegal, redirect_valid;
  logic [31:0]   instr;
  logic [DW-1:0] pc_in, rf_rdata0, rf_rdata1, ex_wr_data, mem_wr_data;
  logic [DW-1:0] out_op1, out_op2, out_imm, out_br_target, redirect_pc;
  logic [AW-1:0] rf_raddr0, rf_raddr1, ex_wr_addr, mem_wr_addr, out_dest;
  logic [4:0]    out_shamt;
  logic [3:0]    out_alu_func;
  logic [1:0]    out_mem_op, out_br_type;

  id_stage_pipe #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc_in(pc_in),
    .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1), .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2),
    .out_imm(out_imm), .out_shamt(out_shamt), .out_dest(out_dest), .out_alu_func(out_alu_func),
    .out_mem_op(out_mem_op), .out_opb_imm(out_opb_imm), .out_br_type(out_br_type),
    .out_br_target(out_br_target), .out_illegal(out_illegal),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  typedef struct packed {
    logic [31:0] op1, op2, imm, bt;
    logic [4:0]  shamt, dest;
    logic [3:0]  alu;
    logic [1:0]  mem, br;
    logic        opb, ill;
  } exp_t;

  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] mem, br, dsel;  // dsel: 0 none, 1 rd, 2 rt
    logic       opb, ill, zext, use_rs, use_rt, is_j, is_jr;
  } dec_t;

  exp_t        sb[$];
  logic [31:0] rf[32];
  int          checks = 0;
  int          errors = 0;
  logic        exp_valid = 1'b0;
  logic        exp_valid_next = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    d = '0;
    if (ins[31:26] == 6'h00) begin
      d.use_rs = 1'b1; d.use_rt = 1'b1; d.dsel = 2'd1;
      case (ins[5:0])
        6'h20: d.alu = 4'd1;
        6'h22: d.alu = 4'd2;
        6'h24: d.alu = 4'd3;
        6'h25: d.alu = 4'd4;
        6'h26: d.alu = 4'd5;
        6'h27: d.alu = 4'd6;
        6'h03: begin d.alu = 4'd7; d.use_rs = 1'b0; end
        6'h2a: d.alu = 4'd8;
        6'h08: begin d.is_jr = 1'b1; d.use_rt = 1'b0; d.dsel = 2'd0; end
        default: begin d.ill = 1'b1; d.use_rs = 1'b0; d.use_rt = 1'b0; d.dsel = 2'd0; end
      endcase
    end else begin
      case (ins[31:26])
        6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h23: begin
          d.use_rs = 1'b1; d.opb = 1'b1; d.dsel = 2'd2;
          d.alu  = (ins[31:26] == 6'h0a) ? 4'd8 : (ins[31:26] == 6'h0c) ? 4'd3 :
                   (ins[31:26] == 6'h0d) ? 4'd4 : (ins[31:26] == 6'h0e) ? 4'd5 : 4'd1;
          d.zext = (ins[31:26] inside {6'h0c, 6'h0d, 6'h0e});
          d.mem  = (ins[31:26] == 6'h23) ? 2'd1 : 2'd0;
        end
        6'h2b: begin d.use_rs = 1'b1; d.use_rt = 1'b1; d.opb = 1'b1; d.alu = 4'd1; d.mem = 2'd2; end
        6'h04: begin d.use_rs = 1'b1; d.use_rt = 1'b1; d.alu = 4'd2; d.br = 2'd1; end
        6'h05: begin d.use_rs = 1'b1; d.use_rt = 1'b1; d.alu = 4'd2; d.br = 2'd2; end
        6'h07: begin d.use_rs = 1'b1; d.alu = 4'd2; d.br = 2'd3; end
        6'h02: d.is_j = 1'b1;
        default: d.ill = 1'b1;
      endcase
    end
    return d;
  endfunction

  function automatic logic [31:0] opval(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
`ifdef ID_FWD_EN
    if (ex_wr_en && ex_wr_addr == r) return ex_wr_data;
    if (mem_wr_en && mem_wr_addr == r) return mem_wr_data;
`endif
    return rf[r];
  endfunction

  function automatic logic stalls_on(input logic used, input logic [4:0] r);
    if (!used || r == 5'd0) return 1'b0;
`ifdef ID_FWD_EN
    return ex_wr_en && ex_is_load && ex_wr_addr == r;
`else
    return (ex_wr_en && ex_wr_addr == r) || (mem_wr_en && mem_wr_addr == r);
`endif
  endfunction

  task automatic drive_cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                             input logic exen, input logic exld, input logic [4:0] exa,
                             input logic [31:0] exd, input logic men, input logic [4:0] ma,
                             input logic [31:0] md, input logic fl, input logic ordy);
    dec_t        d;
    exp_t        e;
    logic [4:0]  rs, rt;
    logic [31:0] op1, op2, simm;
    logic        haz, sfree, rdy, acc;
    @(negedge clk);
    exp_valid = exp_valid_next;
    in_valid = iv; instr = ins; pc_in = pc; flush = fl; out_ready = ordy;
    ex_wr_en = exen; ex_is_load = exld; ex_wr_addr = exa; ex_wr_data = exd;
    mem_wr_en = men; mem_wr_addr = ma; mem_wr_data = md;
    rs = ins[25:21]; rt = ins[20:16];
    rf_rdata0 = rf[rs]; rf_rdata1 = rf[rt];
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    d     = decode(ins);
    op1   = opval(rs);
    op2   = opval(rt);
    haz   = stalls_on(d.use_rs, rs) || stalls_on(d.use_rt, rt);
    sfree = !exp_valid || ordy;
    rdy   = fl || (sfree && !haz);
    acc   = iv && rdy && !fl;
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    chk("rf_raddr", {22'd0, rf_raddr1, rf_raddr0}, {22'd0, rt, rs});
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, acc && (d.is_j || d.is_jr)});
    if (acc && (d.is_j || d.is_jr))
      chk("redirect_pc", redirect_pc, d.is_jr ? op1 : {pc[31:28], ins[25:0], 2'b00});
    if (acc) begin
      simm    = {{16{ins[15]}}, ins[15:0]};
      e.op1   = op1;
      e.op2   = op2;
      e.imm   = d.zext ? {16'd0, ins[15:0]} : simm;
      e.bt    = pc + simm * 4;
      e.shamt = ins[10:6];
      e.dest  = (d.dsel == 2'd1) ? ins[15:11] : (d.dsel == 2'd2) ? rt : 5'd0;
      e.alu   = d.alu;
      e.mem   = d.mem;
      e.br    = d.br;
      e.opb   = d.opb;
      e.ill   = d.ill;
      sb.push_back(e);
    end
    exp_valid_next = fl ? 1'b0 : acc ? 1'b1 : sfree ? 1'b0 : exp_valid;
  endtask

  task automatic idle(input logic ordy);
    drive_cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, ordy);
  endtask

  // Monitor: every presented slot must match the oldest expectation; it retires on handshake or flush.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL slot_unexpected actual=valid required=empty_queue t=%0t", $time);
        end else begin
          e = sb[0];
          chk("out_op1", out_op1, e.op1);
          chk("out_op2", out_op2, e.op2);
          chk("out_imm", out_imm, e.imm);
          chk("out_br_target", out_br_target, e.bt);
          chk("out_fields", {12'd0, out_shamt, out_dest, out_alu_func, out_mem_op, out_br_type},
              {12'd0, e.shamt, e.dest, e.alu, e.mem, e.br});
          chk("out_flags", {30'd0, out_opb_imm, out_illegal}, {30'd0, e.opb, e.ill});
          if (out_ready || flush) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] ins;
    int          k;
    logic [5:0]  rfun[9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h2a, 6'h08};
    logic [5:0]  iops[11] = '{6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h07, 6'h02};
    rst = 1'b0; in_valid = 1'b0; instr = '0; pc_in = '0; flush = 1'b0; out_ready = 1'b0;
    ex_wr_en = 1'b0; ex_is_load = 1'b0; ex_wr_addr = '0; ex_wr_data = '0;
    mem_wr_en = 1'b0; mem_wr_addr = '0; mem_wr_data = '0; rf_rdata0 = '0; rf_rdata1 = '0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[1] = 32'd5; rf[2] = 32'd7;
    #2;
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_op", out_op1 | out_op2 | out_imm | out_br_target, 32'd0);
    chk("reset_fields", {out_shamt, out_dest, out_alu_func, out_mem_op, out_br_type,
                         out_opb_imm, out_illegal, redirect_valid}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // add $3,$1,$2 with rf 5/7
    drive_cycle(1'b1, 32'h00221820, 32'h100, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    idle(1'b1);
    chk("add_example", {out_op1[15:0], out_op2[7:0], out_alu_func, 1'b0, out_dest},
        {16'd5, 8'd7, 4'd1, 1'b0, 5'd3});
    // load-use on $4, then the lw leaves EX
    drive_cycle(1'b1, 32'h2085FFFF, 32'h104, 1'b1, 1'b1, 5'd4, 32'h9, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    drive_cycle(1'b1, 32'h2085FFFF, 32'h104, 1'b0, 1'b0, 5'd4, 32'h9, 1'b1, 5'd4, 32'h44, 1'b0, 1'b1);
    idle(1'b1);
    // EX and MEM both write $1
    drive_cycle(1'b1, 32'h00221820, 32'h108, 1'b1, 1'b0, 5'd1, 32'h11, 1'b1, 5'd1, 32'h22, 1'b0, 1'b1);
    drive_cycle(1'b1, 32'h00221820, 32'h108, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    // j 0x40 from pc_in 0x80000010
    drive_cycle(1'b1, 32'h08000040, 32'h80000010, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    chk("j_example", redirect_pc, 32'h80000100);
    // back-pressure for 3 cycles, then flush
    drive_cycle(1'b1, 32'h00221820, 32'h10c, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b1, 32'hFC000000, 32'h110, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'hFC000000, 32'h110, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    // illegal opcode 0x3f
    drive_cycle(1'b1, 32'hFC000000, 32'h114, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    idle(1'b1);
    // reset while a slot is stalled
    drive_cycle(1'b1, 32'h00221820, 32'h118, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    idle(1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("async_reset_valid", {31'd0, out_valid}, 32'd0);
    sb.delete();
    exp_valid_next = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      k = $urandom_range(0, 20);
      ins = $urandom;
      ins[25:21] = 5'($urandom_range(0, 3));
      ins[20:16] = 5'($urandom_range(0, 3));
      ins[15:11] = 5'($urandom_range(0, 7));
      if (k < 9) begin
        ins[31:26] = 6'h00; ins[5:0] = rfun[k];
      end else if (k < 20) begin
        ins[31:26] = iops[k-9];
      end else begin
        ins[31:26] = ($urandom_range(0, 1) == 0) ? 6'h3f : 6'h00;
        ins[5:0] = 6'h01;
      end
      drive_cycle($urandom_range(0, 9) < 8, ins, {$urandom, 2'b00} & 32'hFFFF_FFFC,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)), $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
